hash_msg_sender: RTL and testbench
==================================

HASH_MSG_SENDER -- requirements
Module: hash_msg_sender

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8 (power of 2, >=2), the byte-buffer depth.
REQ-002 The block SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  a one-cycle request to hash a message of msg_len bytes.
REQ-005 The block SHALL have port msg_len  input  64  the message byte count, sampled when start is accepted.
REQ-006 The block SHALL have ports in_valid  input  1, in_data  input  8 and in_ready  output  1, forming the host byte-stream handshake.
REQ-007 The block SHALL have ports m_valid  output  1, message  output  8 and counter  output  64, which drive the hash core's M_valid, message and counter inputs.
REQ-008 The block SHALL have ports hash_ready  input  1 and digest_in  input  32, taken from the hash core's hash_ready and digest_out.
REQ-009 The block SHALL have ports digest  output  32, digest_valid  output  1 (one-cycle result strobe) and busy  output  1 (a message is in flight).

Function
REQ-010 The block SHALL hold host bytes in a FIFO_DEPTH-entry FIFO; in_ready = !full; a byte is pushed when in_valid && in_ready, whatever the state, including IDLE preload.
REQ-011 When full, the FIFO SHALL refuse a push even if a pop occurs in the same cycle.
REQ-012 The FSM SHALL have the states IDLE, LAUNCH, STREAM and WAIT; busy = (state != IDLE).
REQ-013 In IDLE, start SHALL latch msg_len into counter, clear the 64-bit sent count and move to LAUNCH; start outside IDLE SHALL be ignored.
REQ-014 In LAUNCH with msg_len=0, the block SHALL drive m_valid=1 for one cycle with message=8'h00, pop nothing, and move to WAIT.
REQ-015 In LAUNCH with msg_len>0 and the FIFO non-empty, the block SHALL pop byte 0, drive it on message with m_valid=1 for one cycle, and move to STREAM (or WAIT if msg_len=1); while the FIFO is empty it SHALL stay in LAUNCH with m_valid=0.
REQ-016 In STREAM, each cycle with the FIFO non-empty SHALL pop one byte, present it with m_valid=1 and increment the sent count; an empty FIFO SHALL give m_valid=0 (a gap) with no other change.
REQ-017 After byte msg_len-1 has been issued, the FSM SHALL enter WAIT, and m_valid SHALL never be asserted again until the next launch.
REQ-018 message, m_valid and counter SHALL be registered; counter SHALL hold the latched msg_len from LAUNCH until the return to IDLE.
REQ-019 In WAIT, hash_ready=1 SHALL register digest_in into digest, pulse digest_valid for exactly one cycle, and return to IDLE; hash_ready in any other state SHALL be ignored.
REQ-020 Bytes left in the FIFO beyond msg_len SHALL remain queued for the next message.
REQ-021 Latency: start in IDLE with the FIFO non-empty SHALL give m_valid=1 two cycles later; with no gaps, bytes are issued one per cycle.

Reset
REQ-022 While rst=1: state=IDLE; FIFO empty; m_valid=0, message=0, counter=0, digest=0, digest_valid=0, busy=0; in_ready=1 from the first cycle after reset.
REQ-023 Reset asserted mid-message SHALL abort the transfer and discard all FIFO contents; no digest_valid is produced.

Configuration
REQ-024 With HASH_SENDER_CHECK_EN defined, the block SHALL add ports expected  input  32 (sampled with start) and match  output  1; match is valid with digest_valid and equals (digest_in == expected), and is reset to 0.
REQ-025 Without HASH_SENDER_CHECK_EN, neither port nor the compare logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-026 Preload 8'h61,8'h62,8'h63, then start with msg_len=3 -> m_valid high on three consecutive cycles carrying 61,62,63, counter=3 throughout, busy=1.
REQ-027 start with msg_len=0 and the FIFO empty -> a single m_valid pulse with counter=0; then hash_ready with digest_in=32'hA5A50001 -> digest=32'hA5A50001, digest_valid for one cycle.
REQ-028 start with msg_len=4, pushing bytes only on alternate cycles -> m_valid shows matching gaps, exactly 4 pulses, then WAIT.
REQ-029 Fill FIFO_DEPTH=8 bytes with no start -> in_ready=0; a 9th in_valid is not accepted; start with msg_len=2 -> in_ready returns to 1 after the first pop; 6 bytes remain.
REQ-030 rst asserted during STREAM of msg_len=5 after 2 bytes -> next cycle IDLE, m_valid=0, FIFO empty; a later hash_ready=1 gives no digest_valid.
REQ-031 With HASH_SENDER_CHECK_EN, expected=32'h12345678: digest_in=32'h12345678 gives match=1; digest_in=32'h12345679 gives match=0.

Source files
------------

// File: rtl/hash_msg_sender.sv
// rtl/hash_msg_sender.sv - byte FIFO plus launch/stream/wait sequencer feeding a hash core
// Define HASH_SENDER_CHECK_EN to add the expected/match digest compare ports.
module hash_msg_sender #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] msg_len,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        m_valid,
   output logic [7:0]  message,
   output logic [63:0] counter,
   input  logic        hash_ready,
   input  logic [31:0] digest_in,
   output logic [31:0] digest,
   output logic        digest_valid,
`ifdef HASH_SENDER_CHECK_EN
   input  logic [31:0] expected,
   output logic        match,
`endif
   output logic        busy
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, LAUNCH, STREAM, WAIT} state_t;

   state_t        state_q, state_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          full, empty, push, pop;
   logic [63:0]   counter_q, counter_d;
   logic [63:0]   sent_q, sent_d;
   logic          m_valid_q, m_valid_d;
   logic [7:0]    message_q, message_d;
   logic [31:0]   digest_q, digest_d;
   logic          digest_valid_q, digest_valid_d;

   assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
   assign push     = in_valid && !full;
   assign in_ready = !full;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_comb begin
      state_d        = state_q;
      counter_d      = counter_q;
      sent_d         = sent_q;
      m_valid_d      = 1'b0;
      message_d      = message_q;
      digest_d       = digest_q;
      digest_valid_d = 1'b0;
      pop            = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               counter_d = msg_len;
               sent_d    = '0;
               state_d   = LAUNCH;
            end
         end
         LAUNCH: begin
            // An empty message still gives the core one strobe carrying a zero byte.
            if (counter_q == 64'd0) begin
               m_valid_d = 1'b1;
               message_d = 8'h00;
               state_d   = WAIT;
            end else if (!empty) begin
               pop       = 1'b1;
               m_valid_d = 1'b1;
               message_d = mem_q[rd_ptr_q];
               sent_d    = 64'd1;
               state_d   = (counter_q == 64'd1) ? WAIT : STREAM;
            end
         end
         STREAM: begin
            if (!empty) begin
               pop       = 1'b1;
               m_valid_d = 1'b1;
               message_d = mem_q[rd_ptr_q];
               sent_d    = sent_q + 64'd1;
               if (sent_q + 64'd1 == counter_q) begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (hash_ready) begin
               digest_d       = digest_in;
               digest_valid_d = 1'b1;
               state_d        = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         counter_q      <= '0;
         sent_q         <= '0;
         m_valid_q      <= 1'b0;
         message_q      <= '0;
         digest_q       <= '0;
         digest_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         counter_q      <= counter_d;
         sent_q         <= sent_d;
         m_valid_q      <= m_valid_d;
         message_q      <= message_d;
         digest_q       <= digest_d;
         digest_valid_q <= digest_valid_d;
      end
   end

`ifdef HASH_SENDER_CHECK_EN
   logic [31:0] expected_q;
   logic        match_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         expected_q <= '0;
         match_q    <= 1'b0;
      end else begin
         if (state_q == IDLE && start) begin
            expected_q <= expected;
         end
         if (state_q == WAIT && hash_ready) begin
            match_q <= (digest_in == expected_q);
         end
      end
   end

   assign match = match_q;
`endif

   assign m_valid      = m_valid_q;
   assign message      = message_q;
   assign counter      = counter_q;
   assign digest       = digest_q;
   assign digest_valid = digest_valid_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_hash_msg_sender.sv
// tb/tb_hash_msg_sender.sv - directed and randomized checks of hash_msg_sender against a queue model
module tb_hash_msg_sender;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, in_ready, m_valid, hash_ready, digest_valid, busy;
   logic [63:0] msg_len, counter;
   logic [7:0]  in_data, message;
   logic [31:0] digest_in, digest;
`ifdef HASH_SENDER_CHECK_EN
   logic [31:0] expected;
   logic        match;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  host_q[$];
   logic [7:0]  got_q[$];
   int          pushed = 0;
   int          issued = 0;
   logic [63:0] cur_len = '0;

   hash_msg_sender #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .msg_len(msg_len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .m_valid(m_valid), .message(message), .counter(counter),
      .hash_ready(hash_ready), .digest_in(digest_in),
      .digest(digest), .digest_valid(digest_valid),
`ifdef HASH_SENDER_CHECK_EN
      .expected(expected), .match(match),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: the model accepts a byte only while fewer than DEPTH bytes are held.
   task automatic step();
      int occ;
      occ = pushed - issued;
      if (!rst) begin
         chk("in_ready", in_ready, 64'(occ < DEPTH));
         if (in_valid && occ < DEPTH) begin
            host_q.push_back(in_data);
            pushed++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (m_valid) begin
         chk("counter_during_m_valid", counter, cur_len);
         got_q.push_back(message);
         if (cur_len != 64'd0) issued++;
      end
   endtask

   task automatic drive_push(input int pct);
      in_valid = ($urandom_range(0, 99) < pct);
      in_data  = 8'($urandom);
   endtask

   task automatic start_msg(input logic [63:0] len, input logic [31:0] ex);
      got_q.delete();
      cur_len = len;
      msg_len = len;
      start   = 1'b1;
`ifdef HASH_SENDER_CHECK_EN
      expected = ex;
`endif
      step();
      start = 1'b0;
   endtask

   task automatic finish_msg(input logic [63:0] len, input logic [31:0] dg, input logic [31:0] ex);
      int         need;
      logic [7:0] exp_b, got_b;
      need = (len == 64'd0) ? 1 : int'(len);
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) step();
      chk("pulse_count", 64'(got_q.size()), 64'(need));
      chk("busy_in_wait", busy, 64'd1);
      for (int k = 0; k < need; k++) begin
         if (len == 64'd0) exp_b = 8'h00;
         else if (host_q.size() > 0) exp_b = host_q.pop_front();
         else exp_b = 8'hxx;
         got_b = (k < got_q.size()) ? got_q[k] : 8'hzz;
         chk("msg_byte", got_b, exp_b);
      end
      digest_in  = dg;
      hash_ready = 1'b1;
      step();
      hash_ready = 1'b0;
      chk("digest_valid_pulse", digest_valid, 64'd1);
      chk("digest_value", digest, dg);
      chk("busy_after_digest", busy, 64'd0);
`ifdef HASH_SENDER_CHECK_EN
      chk("match", match, 64'(dg == ex));
`endif
      step();
      chk("digest_valid_one_cycle", digest_valid, 64'd0);
   endtask

   task automatic run_msg(input logic [63:0] len, input int pct, input logic [31:0] dg, input logic [31:0] ex);
      int need;
      int budget;
      need   = (len == 64'd0) ? 1 : int'(len);
      budget = 400;
      drive_push(pct);
      start_msg(len, ex);
      while (got_q.size() < need && budget > 0) begin
         drive_push(pct);
         step();
         budget--;
      end
      chk("msg_within_budget", 64'(budget > 0), 64'd1);
      finish_msg(len, dg, ex);
   endtask

   initial begin
      logic [31:0] dg;
      int          prev_mv, back_to_back, npush;

      rst = 1'b1; start = 1'b0; msg_len = '0; in_valid = 1'b0; in_data = '0;
      hash_ready = 1'b0; digest_in = '0;
`ifdef HASH_SENDER_CHECK_EN
      expected = '0;
`endif
      step();
      chk("rst_in_ready", in_ready, 64'd1);
      step();
      chk("rst_m_valid", m_valid, 64'd0);
      chk("rst_message", message, 64'd0);
      chk("rst_counter", counter, 64'd0);
      chk("rst_digest", digest, 64'd0);
      chk("rst_digest_valid", digest_valid, 64'd0);
      chk("rst_busy", busy, 64'd0);
`ifdef HASH_SENDER_CHECK_EN
      chk("rst_match", match, 64'd0);
`endif
      rst = 1'b0;
      step();

      // Preloaded "abc": three back-to-back strobes, two cycles after start.
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = 8'h61 + 8'(k);
         step();
      end
      in_valid = 1'b0;
      start_msg(64'd3, 32'h0);
      chk("abc_busy", busy, 64'd1);
      chk("abc_latency_gap", m_valid, 64'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("abc_m_valid", m_valid, 64'd1);
         chk("abc_message", message, 64'(8'h61 + 8'(k)));
         chk("abc_counter", counter, 64'd3);
      end
      finish_msg(64'd3, 32'hC0FFEE03, 32'h0);

      // hash_ready while idle must not produce a digest.
      hash_ready = 1'b1;
      digest_in  = 32'hDEAD0000;
      step();
      hash_ready = 1'b0;
      chk("idle_hash_ready_ignored", digest_valid, 64'd0);

      // Zero-length message with an empty FIFO.
      start_msg(64'd0, 32'h0);
      step();
      chk("zero_m_valid", m_valid, 64'd1);
      chk("zero_message", message, 64'd0);
      chk("zero_counter", counter, 64'd0);
      finish_msg(64'd0, 32'hA5A50001, 32'h0);

      // Bytes pushed on alternate cycles give alternating strobes.
      start_msg(64'd4, 32'h0);
      prev_mv = 0; back_to_back = 0; npush = 0;
      for (int k = 0; k < 40 && got_q.size() < 4; k++) begin
         in_valid = (k % 2 == 0) && (npush < 4);
         in_data  = 8'($urandom);
         if (in_valid) npush++;
         step();
         if (m_valid && prev_mv != 0) back_to_back++;
         prev_mv = int'(m_valid);
      end
      chk("alt_no_back_to_back", 64'(back_to_back), 64'd0);
      finish_msg(64'd4, $urandom, 32'h0);

      // Fill the FIFO, offer a ninth byte, then drain 2 + 6.
      for (int k = 0; k < DEPTH; k++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         step();
      end
      chk("full_in_ready_low", in_ready, 64'd0);
      in_data = 8'hEE;
      step();
      in_valid = 1'b0;
      start_msg(64'd2, 32'h0);
      chk("full_in_ready_before_pop", in_ready, 64'd0);
      step();
      chk("in_ready_after_first_pop", in_ready, 64'd1);
      step();
      finish_msg(64'd2, $urandom, 32'h0);
      run_msg(64'd6, 0, $urandom, 32'h0);
      start_msg(64'd1, 32'h0);
      for (int k = 0; k < 5; k++) step();
      chk("ninth_byte_not_kept", 64'(got_q.size()), 64'd0);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 4 && got_q.size() < 1; k++) step();
      finish_msg(64'd1, $urandom, 32'h0);

      // Reset in the middle of a 5-byte message.
      for (int k = 0; k < 7; k++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         step();
      end
      in_valid = 1'b0;
      start_msg(64'd5, 32'h0);
      for (int k = 0; k < 10 && got_q.size() < 2; k++) step();
      chk("pre_reset_two_bytes", 64'(got_q.size()), 64'd2);
      rst = 1'b1;
      step();
      chk("abort_busy", busy, 64'd0);
      chk("abort_m_valid", m_valid, 64'd0);
      chk("abort_in_ready", in_ready, 64'd1);
      rst = 1'b0;
      host_q.delete();
      pushed = 0;
      issued = 0;
      hash_ready = 1'b1;
      digest_in  = 32'hBAD0BAD0;
      step();
      hash_ready = 1'b0;
      chk("abort_no_digest", digest_valid, 64'd0);
      start_msg(64'd1, 32'h0);
      for (int k = 0; k < 4; k++) step();
      chk("abort_fifo_empty", 64'(got_q.size()), 64'd0);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 4 && got_q.size() < 1; k++) step();
      finish_msg(64'd1, $urandom, 32'h0);

`ifdef HASH_SENDER_CHECK_EN
      run_msg(64'd0, 50, 32'h12345678, 32'h12345678);
      run_msg(64'd2, 80, 32'h12345679, 32'h12345678);
`endif

      // Random lengths and push densities; leftover bytes carry into the next message.
      for (int m = 0; m < 12; m++) begin
         dg = $urandom;
         run_msg(64'($urandom_range(0, 12)), int'($urandom_range(30, 100)), dg,
                 ($urandom_range(0, 1) == 1) ? dg : $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
